// File: rtl/rram_pg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rram_pg_pkg
// Description : Shared encodings for the RRAM pattern generator: FSM states,
//               sequence modes, data patterns and access phase.
// Revision    : 1.0  initial release
// ============================================================================
package rram_pg_pkg;

    // FSM state encoding. NEXT is a zero-cycle decision folded into the exit
    // of HOLD/SAMPLE/GAPW; it is encoded for documentation and never held.
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_ISSUE  = 3'd1;
    localparam logic [2:0] c_ST_HOLD   = 3'd2;
    localparam logic [2:0] c_ST_WAIT   = 3'd3;
    localparam logic [2:0] c_ST_SAMPLE = 3'd4;
    localparam logic [2:0] c_ST_GAPW   = 3'd5;
    localparam logic [2:0] c_ST_NEXT   = 3'd6;
    localparam logic [2:0] c_ST_DONE   = 3'd7;

    // Sequence modes
    localparam logic [1:0] MODE_SINGLE = 2'd0;
    localparam logic [1:0] MODE_WSWEEP = 2'd1;
    localparam logic [1:0] MODE_RSWEEP = 2'd2;
    localparam logic [1:0] MODE_VERIFY = 2'd3;

    // Data patterns
    localparam logic [1:0] c_PAT_SOLID   = 2'd0;
    localparam logic [1:0] c_PAT_CHECKER = 2'd1;
    localparam logic [1:0] c_PAT_ADDRESS = 2'd2;
    localparam logic [1:0] c_PAT_INVERT  = 2'd3;

    // Access phase, encoded so it can drive RW directly
    localparam logic c_PH_WRITE = 1'b0;
    localparam logic c_PH_READ  = 1'b1;

endpackage : rram_pg_pkg
`default_nettype wire

// File: rtl/rram_pg_addr_cnt.sv
`default_nettype none
// ============================================================================
// Module      : rram_pg_addr_cnt
// Description : Row/column address counter for the pattern generator.
//               Y is the fast index; a Y wrap carries into X.
// Ports       : clk, rst       clock, asynchronous active-high reset
//               i_load         load (i_load_x, i_load_y); has priority
//               i_inc          advance to the next cell
//               o_x, o_y       current address
//               o_last         current cell is the last cell of the array
// Revision    : 1.0  initial release
// ============================================================================
module rram_pg_addr_cnt #(
    parameter int X_SIZE = 3,
    parameter int Y_SIZE = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [X_SIZE-1:0] i_load_x,
    input  logic [Y_SIZE-1:0] i_load_y,
    input  logic              i_inc,
    output logic [X_SIZE-1:0] o_x,
    output logic [Y_SIZE-1:0] o_y,
    output logic              o_last
);

    logic [X_SIZE-1:0] r_x;
    logic [Y_SIZE-1:0] r_y;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_load) begin
            r_x <= i_load_x;
            r_y <= i_load_y;
        end else if (i_inc) begin
            if (r_y == {Y_SIZE{1'b1}}) begin
                r_y <= '0;
                r_x <= r_x + 1'b1;
            end else begin
                r_y <= r_y + 1'b1;
            end
        end
    end

    assign o_x    = r_x;
    assign o_y    = r_y;
    assign o_last = (r_x == {X_SIZE{1'b1}}) && (r_y == {Y_SIZE{1'b1}});

endmodule : rram_pg_addr_cnt
`default_nettype wire

// File: rtl/rram_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : rram_pattern_gen
// Description : Stimulus engine for the RRAM array controller. Generates
//               single accesses, full-array write / read sweeps and a
//               write-then-verify sweep, checking read data in verify mode.
// Ports       : clk, reset            clock, asynchronous active-high reset
//               start, mode, pattern, seed, single_x/y/rw  request interface
//               Z_RD                  read data from the controller
//               EN, RW, X/Y_ADDRESS_IN, Z_WR, Z_WR_OE  controller access port
//               busy, done            sequence status (done is a 1-cycle pulse)
//               rd_data               last sampled Z_RD
//               err_count, first_err_x/y  verify results
// Revision    : 1.0  initial release
// ============================================================================
module rram_pattern_gen
    import rram_pg_pkg::*;
#(
    parameter int B_SIZE    = 2,
    parameter int X_SIZE    = 3,
    parameter int Y_SIZE    = 4,
    parameter int READ_WAIT = 3,
    parameter int GAP       = 1,
    parameter int ERR_W     = X_SIZE + Y_SIZE + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [1:0]        pattern,
    input  logic [B_SIZE-1:0] seed,
    input  logic [X_SIZE-1:0] single_x,
    input  logic [Y_SIZE-1:0] single_y,
    input  logic              single_rw,
    input  logic [B_SIZE-1:0] Z_RD,
    output logic              EN,
    output logic              RW,
    output logic [X_SIZE-1:0] X_ADDRESS_IN,
    output logic [Y_SIZE-1:0] Y_ADDRESS_IN,
    output logic [B_SIZE-1:0] Z_WR,
    output logic              Z_WR_OE,
    output logic              busy,
    output logic              done,
    output logic [B_SIZE-1:0] rd_data,
    output logic [ERR_W-1:0]  err_count,
    output logic [X_SIZE-1:0] first_err_x,
    output logic [Y_SIZE-1:0] first_err_y
);

    // One down-counter-free cycle counter serves both WAIT and GAPW.
    localparam int c_MAXW  = (READ_WAIT > GAP) ? READ_WAIT : GAP;
    localparam int c_CNT_W = (c_MAXW > 1) ? $clog2(c_MAXW) : 1;
    localparam logic [c_CNT_W-1:0] c_WAIT_LAST = c_CNT_W'(READ_WAIT - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST  = c_CNT_W'((GAP > 0) ? GAP - 1 : 0);

    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_phase;
    logic [1:0]         r_mode;
    logic [1:0]         r_pattern;
    logic [B_SIZE-1:0]  r_seed;
    logic [B_SIZE-1:0]  r_rd_data;
    logic [ERR_W-1:0]   r_err_count;
    logic [X_SIZE-1:0]  r_first_x;
    logic [Y_SIZE-1:0]  r_first_y;

    logic [2:0]         w_state_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               w_phase_nxt;
    logic               w_advance;
    logic               w_load;
    logic [X_SIZE-1:0]  w_load_x;
    logic [Y_SIZE-1:0]  w_load_y;
    logic               w_inc;
    logic [X_SIZE-1:0]  w_x;
    logic [Y_SIZE-1:0]  w_y;
    logic               w_last;
    logic [B_SIZE-1:0]  w_expected;
    logic               w_wr_drive;
    logic               w_in_access;

    // Expected cell contents for a pattern at address (ax, ay).
    function automatic logic [B_SIZE-1:0] f_expected(
        input logic [1:0]        pat,
        input logic [B_SIZE-1:0] sd,
        input logic [X_SIZE-1:0] ax,
        input logic [Y_SIZE-1:0] ay
    );
        // Padding on the left zero-extends {x,y} when B_SIZE is wider.
        logic [B_SIZE+X_SIZE+Y_SIZE-1:0] v_addr;
        v_addr = {{B_SIZE{1'b0}}, ax, ay};
        case (pat)
            c_PAT_SOLID:   f_expected = sd;
            c_PAT_CHECKER: f_expected = (ax[0] ^ ay[0]) ? ~sd : sd;
            c_PAT_ADDRESS: f_expected = v_addr[B_SIZE-1:0];
            default:       f_expected = ~sd;
        endcase
    endfunction

    rram_pg_addr_cnt #(
        .X_SIZE (X_SIZE),
        .Y_SIZE (Y_SIZE)
    ) u_addr_cnt (
        .clk      (clk),
        .rst      (reset),
        .i_load   (w_load),
        .i_load_x (w_load_x),
        .i_load_y (w_load_y),
        .i_inc    (w_inc),
        .o_x      (w_x),
        .o_y      (w_y),
        .o_last   (w_last)
    );

    assign w_expected = f_expected(r_pattern, r_seed, w_x, w_y);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_phase_nxt = r_phase;
        w_advance   = 1'b0;
        w_load      = 1'b0;
        w_load_x    = '0;
        w_load_y    = '0;
        w_inc       = 1'b0;

        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_load = 1'b1;
                    if (mode == MODE_SINGLE) begin
                        w_load_x = single_x;
                        w_load_y = single_y;
                    end
                    w_phase_nxt = ((mode == MODE_RSWEEP) ||
                                   ((mode == MODE_SINGLE) && single_rw)) ? c_PH_READ : c_PH_WRITE;
                    w_state_nxt = c_ST_ISSUE;
                end
            end
            c_ST_ISSUE: begin
                w_state_nxt = c_ST_HOLD;
            end
            c_ST_HOLD: begin
                w_cnt_nxt = '0;
                if (r_phase == c_PH_READ) begin
                    w_state_nxt = c_ST_WAIT;
                end else if (GAP == 0) begin
                    w_advance = 1'b1;
                end else begin
                    w_state_nxt = c_ST_GAPW;
                end
            end
            c_ST_WAIT: begin
                if (r_cnt == c_WAIT_LAST) begin
                    w_state_nxt = c_ST_SAMPLE;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            c_ST_SAMPLE: begin
                w_cnt_nxt = '0;
                if (GAP == 0) begin
                    w_advance = 1'b1;
                end else begin
                    w_state_nxt = c_ST_GAPW;
                end
            end
            c_ST_GAPW: begin
                if (r_cnt == c_GAP_LAST) begin
                    w_advance = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            c_ST_DONE: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase

        // NEXT decision: taken in the same cycle the current access ends.
        // The address is left untouched when the sequence finishes so the
        // last accessed cell stays visible on the address outputs.
        if (w_advance) begin
            if (r_mode == MODE_SINGLE) begin
                w_state_nxt = c_ST_DONE;
            end else if (!w_last) begin
                w_inc       = 1'b1;
                w_state_nxt = c_ST_ISSUE;
            end else if ((r_mode == MODE_VERIFY) && (r_phase == c_PH_WRITE)) begin
                w_load      = 1'b1;
                w_phase_nxt = c_PH_READ;
                w_state_nxt = c_ST_ISSUE;
            end else begin
                w_state_nxt = c_ST_DONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_phase     <= c_PH_WRITE;
            r_mode      <= MODE_SINGLE;
            r_pattern   <= c_PAT_SOLID;
            r_seed      <= '0;
            r_rd_data   <= '0;
            r_err_count <= '0;
            r_first_x   <= '0;
            r_first_y   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_phase <= w_phase_nxt;

            if ((r_state == c_ST_IDLE) && start) begin
                r_mode      <= mode;
                r_pattern   <= pattern;
                r_seed      <= seed;
                r_err_count <= '0;
                r_first_x   <= '0;
                r_first_y   <= '0;
            end

            if (r_state == c_ST_SAMPLE) begin
                r_rd_data <= Z_RD;
                if ((r_mode == MODE_VERIFY) && (Z_RD != w_expected)) begin
                    if (r_err_count != {ERR_W{1'b1}}) begin
                        r_err_count <= r_err_count + 1'b1;
                    end
                    // A zero count means no mismatch has been seen yet.
                    if (r_err_count == '0) begin
                        r_first_x <= w_x;
                        r_first_y <= w_y;
                    end
                end
            end
        end
    end

    assign w_in_access = (r_state == c_ST_ISSUE) || (r_state == c_ST_HOLD) ||
                         (r_state == c_ST_WAIT)  || (r_state == c_ST_SAMPLE);
    assign w_wr_drive  = ((r_state == c_ST_ISSUE) || (r_state == c_ST_HOLD)) &&
                         (r_phase == c_PH_WRITE);

    assign EN           = (r_state == c_ST_ISSUE);
    assign RW           = w_in_access & r_phase;
    assign X_ADDRESS_IN = w_x;
    assign Y_ADDRESS_IN = w_y;
    assign Z_WR         = w_wr_drive ? w_expected : '0;
    assign Z_WR_OE      = w_wr_drive;
    assign busy         = (r_state != c_ST_IDLE);
    assign done         = (r_state == c_ST_DONE);
    assign rd_data      = r_rd_data;
    assign err_count    = r_err_count;
    assign first_err_x  = r_first_x;
    assign first_err_y  = r_first_y;

endmodule : rram_pattern_gen
`default_nettype wire

// File: doc/rram_pattern_gen.md
Name: rram_pattern_gen

Overview:
- Synthesizable, parametrised stimulus engine for the RRAM array controller.
- Generates EN/RW/X/Y/Z_WR access sequences that were previously scripted by hand: single access, full-array write sweep, full-array read sweep, and write-then-verify sweep.
- In verify mode it compares read data against the expected pattern and reports errors.
- Sits between the test/config interface and the controller's access port, usable in simulation and on silicon.

Parameters:
B_SIZE, 2, data width per cell access (Z_WR/Z_RD)
X_SIZE, 3, row address width
Y_SIZE, 4, column address width
READ_WAIT, 3, idle cycles after the read EN pulse before Z_RD is sampled (>=1)
GAP, 1, idle cycles between consecutive accesses (>=0)
ERR_W, X_SIZE+Y_SIZE+1, error counter width

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle request; sampled only in IDLE
mode  input  2  0 single, 1 write sweep, 2 read sweep, 3 write-then-verify
pattern  input  2  0 solid, 1 checkerboard, 2 address, 3 inverted solid
seed  input  B_SIZE  base data value for the patterns
single_x  input  X_SIZE  row for mode 0
single_y  input  Y_SIZE  column for mode 0
single_rw  input  1  mode 0 direction: 0 write, 1 read
Z_RD  input  B_SIZE  read data from controller
EN  output  1  access enable pulse to controller
RW  output  1  0 write, 1 read
X_ADDRESS_IN  output  X_SIZE  row address
Y_ADDRESS_IN  output  Y_SIZE  column address
Z_WR  output  B_SIZE  write data
Z_WR_OE  output  1  write-data drive enable (replaces tri-state release)
busy  output  1  sequence in progress
done  output  1  one-cycle pulse at sequence end
rd_data  output  B_SIZE  last sampled Z_RD
err_count  output  ERR_W  verify mismatches, saturating
first_err_x  output  X_SIZE  row of first mismatch
first_err_y  output  Y_SIZE  column of first mismatch

Behaviour:
- Reset: all outputs 0; FSM in IDLE; inputs ignored while reset is high. Reset mid-sequence aborts immediately; done does not pulse.
- FSM states: IDLE, ISSUE, HOLD, WAIT, SAMPLE, GAPW, NEXT, DONE.
- IDLE: on start=1, latch mode, pattern and seed (and single_* for mode 0). Clear err_count and first_err_*. Set address to (single_x, single_y) for mode 0, else (0,0). Phase is WRITE unless mode 2, or mode 0 with single_rw=1. Go to ISSUE; busy=1 from the next cycle.
- start while busy is ignored. Inputs are not re-sampled mid-sequence.
- ISSUE (1 cycle): EN=1; RW=phase; addresses driven. Write phase: Z_WR=expected, Z_WR_OE=1.
- HOLD (1 cycle): EN=0; addresses and write data held.
  - Write: Z_WR_OE drops to 0 on exit (Z_WR returns to 0); go to GAPW.
  - Read: go to WAIT.
- WAIT: READ_WAIT cycles, EN=0, then SAMPLE.
- SAMPLE (1 cycle): rd_data<=Z_RD at the exiting edge.
  - Mode 3 only: if Z_RD!=expected, err_count increments (saturating at all-ones). On the first mismatch, the current address is captured in first_err_x/y.
- GAPW: GAP cycles idle (skipped when GAP=0), then NEXT.
- NEXT (0-cycle decision, combinational with GAPW exit): Y increments; on Y wrap, Y->0 and X increments.
  - Last cell is (2^X_SIZE-1, 2^Y_SIZE-1). After it:
    - mode 3 write phase: phase becomes READ, address to (0,0), go to ISSUE;
    - otherwise go to DONE.
  - Mode 0 always goes to DONE after one access.
- DONE (1 cycle): done=1, busy=0 on exit, return to IDLE. Addresses keep their last value; rd_data and err_* persist until the next start.
- Expected data at (x,y):
  - solid = seed;
  - checkerboard = seed if x[0]^y[0]==0, else ~seed;
  - address = low B_SIZE bits of {x,y}, zero-extended if B_SIZE > X_SIZE+Y_SIZE;
  - inverted = ~seed.
- Cycle counts per access:
  - write = 2+GAP;
  - read = 3+READ_WAIT+GAP.
- With defaults (128 cells):
  - write sweep = 384 cycles start-to-done;
  - read sweep = 896 cycles;
  - verify = 1280 cycles.

Decomposition:
- Package rram_pg_pkg holds:
  - FSM state encoding;
  - mode constants (MODE_SINGLE, MODE_WSWEEP, MODE_RSWEEP, MODE_VERIFY);
  - pattern constants;
  - phase constants.
- One sub-module: rram_pg_addr_cnt, the X/Y counter with load, increment, and last-cell flag.
- Expected-data generation is an in-module function.

Test Plan:
- Reset while mid-write-sweep at cell (2,5) -> all outputs 0 next cycle; no done pulse; next start runs a clean sweep from (0,0).
- Mode 0 write, x=6, y=15, seed=2'b10 -> one EN pulse with RW=0, X=6, Y=15, Z_WR=10 and OE=1 for exactly 2 cycles; done at cycle 4 after start.
- Mode 1, pattern checkerboard, seed=2'b01 -> 128 EN pulses, 3 cycles apart, Y fastest; Z_WR=01 at (0,0), 10 at (0,1), 10 at (1,0); done 384 cycles after start.
- Mode 3, pattern address, model echoes writes -> err_count=0, done after 1280 cycles, busy low after done.
- Mode 3, model corrupts cells (3,7) and (5,2) -> err_count=2, first_err_x=3, first_err_y=7.
- start pulsed while busy and at the done cycle -> ignored; start in IDLE after done accepted; saturation check with every read corrupted and ERR_W=3 -> err_count holds 7.
